// File: rtl/dac_spi_writer.sv
// -----------------------------------------------------------------------------
// dac_spi_writer
//   Consumes the filter output stream (dv/chan/data), keeps the most recent
//   value per channel, clamps it to the DAC code range, and writes it to an
//   8-channel, 16-bit SPI DAC. Pending channels are served round-robin.
//
//   Frame (24 bits, MSB first): {4'b0011, chan[3:0], code[15:0]}
//   The DAC samples dac_sdi on the rising edge of dac_sclk.
//
// Ports
//   clk_in     system clock
//   rst_in     asynchronous active-low reset
//   dv_in      input sample valid
//   chan_in    input channel (values >= N_CHAN are ignored)
//   data_in    signed input value
//   dac_cs_n   DAC chip select, active-low
//   dac_sclk   DAC serial clock, idles low
//   dac_sdi    DAC serial data, MSB first
//   busy_out   high while a frame is in progress (LOAD..GAP)
//   done_out   one-cycle pulse when a frame completes
//   done_chan  channel of the completed frame, valid with done_out
//   ovw_cnt    saturating count of pending values overwritten before sending
// -----------------------------------------------------------------------------
module dac_spi_writer #(
    parameter int W_CHAN   = 5,
    parameter int N_CHAN   = 8,
    parameter int W_DIN    = 64,
    parameter int W_DAC    = 16,
    parameter int SCLK_DIV = 4,
    parameter int CS_GAP   = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    dv_in,
    input  logic [W_CHAN-1:0]       chan_in,
    input  logic signed [W_DIN-1:0] data_in,
    output logic                    dac_cs_n,
    output logic                    dac_sclk,
    output logic                    dac_sdi,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [W_CHAN-1:0]       done_chan,
    output logic [15:0]             ovw_cnt
);

    localparam int W_PTR = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int W_DIV = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int W_GAP = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [W_DIV-1:0]   div_q, div_d;
    logic [4:0]         bit_q, bit_d;
    logic [W_GAP-1:0]   gap_q, gap_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic [23:0]        shreg_q, shreg_d;
    logic               done_q, done_d;
    logic [W_CHAN-1:0]  done_chan_q, done_chan_d;
    logic [W_PTR-1:0]   cur_q, cur_d;
    logic [W_PTR-1:0]   rr_q, rr_d;
    logic [N_CHAN-1:0]  pend_vld_q, pend_vld_d;
    logic [15:0]        ovw_q, ovw_d;

    logic [W_DAC-1:0]   pend_data [N_CHAN];

    // ---------------- capture and clamp ----------------
    logic               cap;
    logic [W_PTR-1:0]   cap_idx;
    logic [W_DAC-1:0]   code_in;

    assign cap     = dv_in && ({1'b0, chan_in} < (W_CHAN+1)'(N_CHAN));
    assign cap_idx = W_PTR'(chan_in);

    always_comb begin
        // Negative -> 0; anything above the code range -> full scale.
        if (data_in[W_DIN-1])
            code_in = '0;
        else if (|data_in[W_DIN-2:W_DAC])
            code_in = '1;
        else
            code_in = data_in[W_DAC-1:0];
    end

    // NOTE: pend_data has no reset; pend_vld (which is reset) gates every read,
    // so clearing the storage itself would only cost reset fan-out.
    always_ff @(posedge clk_in) begin
        if (cap)
            pend_data[cap_idx] <= code_in;
    end

    // ---------------- round-robin pick ----------------
    logic [W_PTR-1:0]   pick;
    logic               pick_vld;
    logic [W_PTR:0]     rr_sum;

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        rr_sum   = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            rr_sum = {1'b0, rr_q} + (W_PTR+1)'(i);
            if (rr_sum >= (W_PTR+1)'(N_CHAN))
                rr_sum = rr_sum - (W_PTR+1)'(N_CHAN);
            if (!pick_vld && pend_vld_q[rr_sum[W_PTR-1:0]]) begin
                pick_vld = 1'b1;
                pick     = rr_sum[W_PTR-1:0];
            end
        end
    end

    // Old data goes into the frame even if the same channel is captured now.
    logic [15:0] code16;
    logic [23:0] frame;
    logic        load_go;

    assign code16  = 16'(pend_data[pick]) << (16 - W_DAC);
    assign frame   = {4'b0011, 4'(pick), code16};
    assign load_go = (state_q == S_IDLE) && pick_vld;

    // ---------------- next-state / outputs ----------------
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        shreg_d     = shreg_q;
        done_d      = 1'b0;
        done_chan_d = done_chan_q;
        cur_d       = cur_q;
        rr_d        = rr_q;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_LOAD;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    shreg_d = frame;
                    cur_d   = pick;
                    rr_d    = (pick == W_PTR'(N_CHAN-1)) ? '0 : pick + 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                div_d   = '0;
                bit_d   = '0;
            end
            S_SHIFT: begin
                if (div_q == W_DIV'(SCLK_DIV-1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == 5'd23) begin
                        state_d     = S_GAP;
                        sclk_d      = 1'b0;
                        cs_n_d      = 1'b1;
                        shreg_d     = '0;
                        gap_d       = '0;
                        done_d      = 1'b1;
                        done_chan_d = W_CHAN'(cur_q);
                    end else begin
                        // Falling sclk: present the next bit.
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[22:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == W_GAP'(CS_GAP-1))
                    state_d = S_IDLE;
                else
                    gap_d = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A capture racing the load of its own channel re-arms the flag and
        // is not an overwrite; the set wins over the load's clear.
        pend_vld_d = pend_vld_q;
        if (load_go)
            pend_vld_d[pick] = 1'b0;
        if (cap)
            pend_vld_d[cap_idx] = 1'b1;

        ovw_d = ovw_q;
        if (cap && pend_vld_q[cap_idx] && !(load_go && pick == cap_idx)
            && ovw_q != 16'hFFFF)
            ovw_d = ovw_q + 16'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            shreg_q     <= '0;
            done_q      <= 1'b0;
            done_chan_q <= '0;
            cur_q       <= '0;
            rr_q        <= '0;
            pend_vld_q  <= '0;
            ovw_q       <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            shreg_q     <= shreg_d;
            done_q      <= done_d;
            done_chan_q <= done_chan_d;
            cur_q       <= cur_d;
            rr_q        <= rr_d;
            pend_vld_q  <= pend_vld_d;
            ovw_q       <= ovw_d;
        end
    end

    assign dac_cs_n  = cs_n_q;
    assign dac_sclk  = sclk_q;
    assign dac_sdi   = shreg_q[23];
    assign busy_out  = (state_q != S_IDLE);
    assign done_out  = done_q;
    assign done_chan = done_chan_q;
    assign ovw_cnt   = ovw_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_writer
//   Directed bench for dac_spi_writer with SCLK_DIV=4, CS_GAP=2. Each frame is
//   decoded from the pins (sdi sampled on sclk rising) and compared with
//   hand-computed words.
// -----------------------------------------------------------------------------
module tb_dac_spi_writer;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic               dv_in = 1'b0;
    logic [4:0]         chan_in = '0;
    logic signed [63:0] data_in = '0;
    logic               dac_cs_n, dac_sclk, dac_sdi, busy_out, done_out;
    logic [4:0]         done_chan;
    logic [15:0]        ovw_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    dac_spi_writer #(
        .W_CHAN(5), .N_CHAN(8), .W_DIN(64), .W_DAC(16), .SCLK_DIV(4), .CS_GAP(2)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .dv_in     (dv_in),
        .chan_in   (chan_in),
        .data_in   (data_in),
        .dac_cs_n  (dac_cs_n),
        .dac_sclk  (dac_sclk),
        .dac_sdi   (dac_sdi),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .done_chan (done_chan),
        .ovw_cnt   (ovw_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Presents one sample; it is captured on the next rising edge.
    task automatic write_word(input logic [4:0] ch, input logic signed [63:0] d);
        dv_in   = 1'b1;
        chan_in = ch;
        data_in = d;
        @(posedge clk_in);
        #1;
        dv_in   = 1'b0;
        chan_in = '0;
        data_in = '0;
    endtask

    // Waits (bounded) for cs_n low, then decodes until cs_n returns high.
    task automatic get_frame(output logic [23:0] word, output int low_cycles,
                             output logic seen_done, output logic [4:0] seen_chan);
        int   waited;
        logic prev;
        waited = 0;
        while (dac_cs_n && waited < 2000) begin
            @(posedge clk_in);
            #1;
            waited++;
        end
        check("frame_started", {31'b0, dac_cs_n}, 32'd0);
        word       = '0;
        low_cycles = 0;
        prev       = dac_sclk;
        while (!dac_cs_n && low_cycles < 1000) begin
            @(posedge clk_in);
            #1;
            low_cycles++;
            if (dac_sclk && !prev)
                word = {word[22:0], dac_sdi};
            prev = dac_sclk;
        end
        seen_done = done_out;
        seen_chan = done_chan;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] word;
        int          low;
        logic        dn;
        logic [4:0]  dch;
        logic        saw_cs, saw_done;
        int          nrise, guard;
        logic        prev;

        // ---- T1: reset / idle ----
        tick(3);
        check("t1_rst_cs_n",      {31'b0, dac_cs_n}, 32'd1);
        check("t1_rst_sclk",      {31'b0, dac_sclk}, 32'd0);
        check("t1_rst_sdi",       {31'b0, dac_sdi},  32'd0);
        check("t1_rst_busy",      {31'b0, busy_out}, 32'd0);
        check("t1_rst_done",      {31'b0, done_out}, 32'd0);
        check("t1_rst_done_chan", {27'b0, done_chan}, 32'd0);
        check("t1_rst_ovw",       {16'b0, ovw_cnt},  32'd0);
        rst_in = 1'b1;
        saw_cs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!dac_cs_n) saw_cs = 1'b1;
        end
        check("t1_idle_no_frame", {31'b0, saw_cs}, 32'd0);

        // Out-of-range channel is ignored.
        write_word(5'd8, 64'sh1234);
        saw_cs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!dac_cs_n) saw_cs = 1'b1;
        end
        check("t1_chan8_ignored", {31'b0, saw_cs}, 32'd0);

        // ---- T2: single write, latency and framing ----
        write_word(5'd2, 64'sh1234);
        check("t2_cs_after_edge1", {31'b0, dac_cs_n}, 32'd1);
        tick(1);
        check("t2_cs_after_edge2", {31'b0, dac_cs_n}, 32'd0);
        check("t2_busy",           {31'b0, busy_out}, 32'd1);
        get_frame(word, low, dn, dch);
        check("t2_word",      {8'b0, word}, 32'h0032_1234);
        check("t2_low_len",   low,          32'd193);
        check("t2_done",      {31'b0, dn},  32'd1);
        check("t2_done_chan", {27'b0, dch}, 32'd2);
        tick(1);
        check("t2_done_pulse_ends", {31'b0, done_out}, 32'd0);

        // ---- T3: clamp ----
        tick(5);
        write_word(5'd4, -64'sd5);
        get_frame(word, low, dn, dch);
        check("t3_neg_clamp", {8'b0, word}, 32'h0034_0000);
        write_word(5'd4, 64'sh1_0000);
        get_frame(word, low, dn, dch);
        check("t3_over_clamp", {8'b0, word}, 32'h0034_FFFF);
        write_word(5'd4, 64'sh0_FFFF);
        get_frame(word, low, dn, dch);
        check("t3_full_scale", {8'b0, word}, 32'h0034_FFFF);

        // ---- T4: round-robin and overwrite ----
        tick(5);
        write_word(5'd0, 64'sh0000);
        tick(1);
        check("t4_chan0_started", {31'b0, dac_cs_n}, 32'd0);
        write_word(5'd3, 64'shAAAA);
        write_word(5'd1, 64'sh0B0B);
        write_word(5'd3, 64'sh0C0C);
        check("t4_ovw_one", {16'b0, ovw_cnt}, 32'd1);
        get_frame(word, low, dn, dch);
        check("t4_chan0_done_chan", {27'b0, dch}, 32'd0);
        get_frame(word, low, dn, dch);
        check("t4_first_chan1", {8'b0, word}, 32'h0031_0B0B);
        get_frame(word, low, dn, dch);
        check("t4_then_chan3",  {8'b0, word}, 32'h0033_0C0C);
        check("t4_chan3_done",  {27'b0, dch}, 32'd3);

        // ---- T5: capture in the same cycle as the load of that channel ----
        tick(5);
        write_word(5'd5, 64'sh5555);
        write_word(5'd5, 64'sh6666);
        check("t5_cs_fell",   {31'b0, dac_cs_n}, 32'd0);
        check("t5_ovw_still", {16'b0, ovw_cnt},  32'd1);
        get_frame(word, low, dn, dch);
        check("t5_old_value", {8'b0, word}, 32'h0035_5555);
        check("t5_low_len",   low,          32'd193);
        get_frame(word, low, dn, dch);
        check("t5_new_value", {8'b0, word}, 32'h0035_6666);

        // ---- T6: reset mid-frame ----
        tick(5);
        write_word(5'd6, 64'sh7777);
        guard = 0;
        while (dac_cs_n && guard < 100) begin
            tick(1);
            guard++;
        end
        nrise = 0;
        prev  = dac_sclk;
        guard = 0;
        while (nrise < 10 && guard < 500) begin
            tick(1);
            if (dac_sclk && !prev) nrise++;
            prev = dac_sclk;
            guard++;
        end
        check("t6_reached_bit10", nrise, 32'd10);
        #3 rst_in = 1'b0;
        #1;
        check("t6_async_cs_n", {31'b0, dac_cs_n}, 32'd1);
        check("t6_async_sclk", {31'b0, dac_sclk}, 32'd0);
        check("t6_async_busy", {31'b0, busy_out}, 32'd0);
        check("t6_async_ovw",  {16'b0, ovw_cnt},  32'd0);
        tick(3);
        rst_in   = 1'b1;
        saw_cs   = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (!dac_cs_n) saw_cs = 1'b1;
            if (done_out)  saw_done = 1'b1;
        end
        check("t6_no_frame_after", {31'b0, saw_cs},   32'd0);
        check("t6_no_done_after",  {31'b0, saw_done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
